// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/redirect controller for branch and exception hazards
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES  = 6,
  parameter int RN_STAGE    = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rob_full,
  input  logic                  rename_fail,
  input  logic                  inst_ready,
  input  logic                  branch_occur,
  input  logic                  exc_req,
  input  logic                  rob_empty,
  input  logic                  stall_cnt_clr,
  output logic                  inst_req,
  output logic [2:0]            pc_src_sel,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  branch_flush,
  output logic                  exc_ack,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int HW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);
  localparam logic [1:0] RUN       = 2'b00;
  localparam logic [1:0] BR_HOLD   = 2'b01;
  localparam logic [1:0] EXC_DRAIN = 2'b10;
  localparam logic [1:0] EXC_REDIR = 2'b11;
  localparam logic [NUM_STAGES-1:0] ALL_M = {NUM_STAGES{1'b1}};
  localparam logic [NUM_STAGES-1:0] PRE_RN_M = ALL_M >> (NUM_STAGES - RN_STAGE);
  localparam logic [NUM_STAGES-1:0] PRE_EX_M = ALL_M >> 1;
  logic [1:0]       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] norm_stall, norm_flush;
  assign norm_stall = (rob_full ? PRE_EX_M : '0) | (rename_fail ? PRE_RN_M : '0) | NUM_STAGES'(!inst_ready);
  assign norm_flush = NUM_STAGES'(rename_fail & !rob_full) << RN_STAGE;
  assign state_o    = state_q;
  assign stall_cnt  = cnt_q;
  // Per-state output equations and next-state; a branch overrides outputs everywhere except the redirect cycle
  always_comb begin
    stall        = norm_stall;
    flush        = norm_flush;
    inst_req     = !(rob_full | rename_fail);
    pc_src_sel   = 3'b000;
    branch_flush = 1'b0;
    exc_ack      = 1'b0;
    state_d      = state_q;
    hold_d       = hold_q;
    case (state_q)
      BR_HOLD: begin
        stall[0] = 1'b1;
        inst_req = 1'b0;
        hold_d   = hold_q - HW'(1);
        state_d  = hold_q <= HW'(1) ? RUN : BR_HOLD;
      end
      EXC_DRAIN: begin
        stall    = PRE_EX_M;
        flush    = '0;
        inst_req = 1'b0;
        state_d  = rob_empty ? EXC_REDIR : EXC_DRAIN;
      end
      EXC_REDIR: begin
        stall      = '0;
        flush      = ALL_M;
        inst_req   = 1'b0;
        pc_src_sel = 3'b010;
        exc_ack    = 1'b1;
        state_d    = HOLD_CYCLES > 0 ? BR_HOLD : RUN;
        hold_d     = HOLD_LD;
      end
      default: state_d = exc_req ? EXC_DRAIN : RUN;
    endcase
    if (branch_occur && state_q != EXC_REDIR) begin
      branch_flush = 1'b1;
      flush        = ALL_M;
      stall        = NUM_STAGES'(!inst_ready);
      pc_src_sel   = 3'b001;
      inst_req     = 1'b0;
      if (state_q != EXC_DRAIN) begin
        state_d = HOLD_CYCLES > 0 ? BR_HOLD : RUN;
        hold_d  = HOLD_LD;
      end
    end
  end
  // Saturating fetch-stall counter; clear wins over increment
  always_comb cnt_d = stall_cnt_clr ? '0 : (stall[0] && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  // State, hold counter and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 6, number of pipeline stages; index 0 = fetch, index NUM_STAGES-1 = execute.
REQ-002 SHALL have parameter RN_STAGE, default 3, index of the rename-to-issue-buffer stage; legal range 1..NUM_STAGES-2.
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, fetch-hold cycles after any redirect; 0 permitted.
REQ-004 SHALL have parameter CNT_W, default 32, stall-counter width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have inputs rob_full, rename_fail, inst_ready, branch_occur, exc_req, rob_empty and stall_cnt_clr, each 1 bit, level-sensitive.
REQ-008 SHALL have output inst_req, 1, fetch request.
REQ-009 SHALL have output pc_src_sel, 3, PC mux select: 000 sequential, 001 branch target, 010 exception vector.
REQ-010 SHALL have outputs stall and flush, NUM_STAGES each, one bit per stage.
REQ-011 SHALL have outputs branch_flush (1), exc_ack (1), state_o (2) and stall_cnt (CNT_W).

Function
REQ-012 SHALL hold a registered FSM with states RUN=00, BR_HOLD=01, EXC_DRAIN=10, EXC_REDIR=11, driven onto state_o; all other outputs are combinational from state, hold counter and inputs.
REQ-013 RUN, no event: stall[0] = rob_full|rename_fail|!inst_ready; stall[1..RN_STAGE-1] = rob_full|rename_fail; stall[RN_STAGE..NUM_STAGES-2] = rob_full; stall[NUM_STAGES-1] = 0.
REQ-014 RUN, no event: flush[RN_STAGE] = rename_fail&!rob_full; all other flush bits 0; inst_req = !(rob_full|rename_fail); pc_src_sel = 000.
REQ-015 branch_occur in RUN or BR_HOLD: branch_flush=1, all flush bits 1, all stall bits 0 except stall[0]=!inst_ready, pc_src_sel=001, inst_req=0 that cycle; next state BR_HOLD with hold counter loaded to HOLD_CYCLES, or RUN if HOLD_CYCLES=0.
REQ-016 BR_HOLD: stall[0]=1, inst_req=0, other stalls per REQ-013; counter decrements each cycle; exits to RUN after the cycle in which it reads 1; branch_occur re-arms per REQ-015.
REQ-017 exc_req in RUN without branch_occur: next state EXC_DRAIN; branch_occur in the same cycle wins and exc_req is deferred (requester holds exc_req until exc_ack).
REQ-018 EXC_DRAIN: stall[0..NUM_STAGES-2]=1, stall[NUM_STAGES-1]=0, inst_req=0; branch_occur produces the REQ-015 outputs but the state stays EXC_DRAIN; rob_empty=1 -> EXC_REDIR.
REQ-019 EXC_REDIR, exactly one cycle: all flush bits 1, pc_src_sel=010, exc_ack=1, branch_flush=0, inst_req=0, branch_occur ignored; next state BR_HOLD with counter HOLD_CYCLES, or RUN if HOLD_CYCLES=0.
REQ-020 stall_cnt: +1 on each cycle stall[0]=1; saturates at all-ones; stall_cnt_clr=1 loads 0 and overrides increment.
REQ-021 exc_ack SHALL be 1 only in EXC_REDIR; branch_flush SHALL equal branch_occur except in EXC_REDIR.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state RUN (state_o=00), hold counter 0, stall_cnt 0, exc_ack 0; combinational outputs follow RUN equations while in reset.
REQ-023 reset mid-EXC_DRAIN or mid-BR_HOLD SHALL abandon the operation; no exc_ack is issued after reset release.

Verification
REQ-024 Defaults; RUN; rename_fail=1, rob_full=0 -> stall=6'b000111, flush=6'b001000, inst_req=0.
REQ-025 branch_occur one cycle -> that cycle flush=6'b111111, pc_src_sel=001; next 2 cycles state_o=01, inst_req=0, stall[0]=1; cycle 3 state_o=00.
REQ-026 branch_occur in the 2nd BR_HOLD cycle -> counter reloads; 2 further hold cycles follow.
REQ-027 exc_req=1, rob_empty=0 for 4 cycles then 1 -> state_o 10 x4, then one cycle 11 with exc_ack=1, pc_src_sel=010, flush all ones, then 2 cycles 01, then 00.
REQ-028 branch_occur and exc_req same cycle -> pc_src_sel=001, state_o=01; exc_req held -> EXC_DRAIN entered from RUN after the hold ends.
REQ-029 CNT_W=4, stall[0] held 20 cycles -> stall_cnt stops at 15; stall_cnt_clr -> 0 next cycle; rst_n low mid-drain -> state_o=00 immediately.
